ref_sram: RTL and testbench

Reference-window buffer for the motion-estimation datapath. It fetches a 23x23-pixel search window for one 8x8 current block from external reference memory (`ref_mem`), 64 bits per word. Once the window is loaded, it streams it to the SAD array one 23-pixel row per cycle. It then pulses `next_block` and advances to the next block in raster order.

---
 rtl/ref_sram_if.sv | 27 ++
 rtl/ref_sram.sv | 152 +++++++++++++++
 tb/tb_ref_sram.sv | 146 ++++++++++++++
 3 files changed

// File: rtl/ref_sram_if.sv
// ref_sram_if
// Bundles the reference-window buffer's fetch and stream signals.
//   en           : fetch enable from the integrator
//   ref_in       : registered 64-bit reference word, pixel 0 in [63:56]
//   ref_out      : one 23-pixel window row, pixel 0 in [183:176]
//   ref_mem_addr : word address toward the reference memory
//   sram_ready   : ref_out carries a valid window row
//   next_block   : one-cycle pulse when a block has been fully streamed
// The master modport is the integrator side; the slave modport is the buffer.
interface ref_sram_if;
  logic         en;
  logic [63:0]  ref_in;
  logic [183:0] ref_out;
  logic [31:0]  ref_mem_addr;
  logic         sram_ready;
  logic         next_block;

  modport master (
    output en, ref_in,
    input  ref_out, ref_mem_addr, sram_ready, next_block
  );

  modport slave (
    input  en, ref_in,
    output ref_out, ref_mem_addr, sram_ready, next_block
  );
endinterface

// File: rtl/ref_sram.sv
// ref_sram
// Reference-window buffer for motion estimation. For each 8x8 block it fetches
// a 23-row x 3-word search window from reference memory, then streams the
// window one 23-pixel row per cycle, pulses next_block and moves to the next
// block in raster order.
// Ports:
//   clk : rising-edge clock
//   rst : synchronous active-high reset
//   bus : ref_sram_if.slave (en, ref_in in; ref_out, ref_mem_addr,
//         sram_ready, next_block out, all outputs registered)
module ref_sram #(
  parameter int FRAME_W_WORDS = 8,
  parameter int FRAME_H       = 64
) (
  input  logic      clk,
  input  logic      rst,
  ref_sram_if.slave bus
);

  localparam logic [7:0]  BX_MAX   = 8'(FRAME_W_WORDS - 2);
  localparam logic [7:0]  BY_MAX   = 8'(FRAME_H / 8 - 2);
  localparam logic [31:0] ROW_STEP = 32'(FRAME_W_WORDS - 2);
  localparam logic [31:0] BAND     = 32'(FRAME_W_WORDS * 8);
  localparam logic [6:0]  LAST_IDX = 7'd68;
  localparam logic [6:0]  NUM_WORDS = 7'd69;
  localparam logic [4:0]  LAST_ROW = 5'd22;

  typedef enum logic [1:0] {IDLE, FILL, STREAM, DONE} state_t;

  state_t      state, state_next;
  logic [31:0] addr;
  logic [6:0]  issue_cnt;
  logic [6:0]  cap_cnt;
  logic [1:0]  word_cnt;
  logic [4:0]  row_cnt;
  logic        cap_valid;
  logic [7:0]  bx, by, bx_next, by_next;
  logic        issue;
  logic        last_capture;
  logic [4:0]  rd_row;
  logic [6:0]  rd_base;
  logic [183:0] row_data;
  logic [63:0] ram [0:68];

  // First word of block (x,y): top-left word of the window, one word left of
  // the block and one block-row (8 lines) above it.
  function automatic logic [31:0] block_base(input logic [7:0] x, input logic [7:0] y);
    return (32'(y) - 32'd1) * BAND + 32'(x) - 32'd1;
  endfunction

  assign issue        = (state == FILL) && bus.en && (issue_cnt < NUM_WORDS);
  assign last_capture = (state == FILL) && cap_valid && (cap_cnt == LAST_IDX);

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (bus.en) state_next = FILL;
      FILL:    if (last_capture) state_next = STREAM;
      STREAM:  if (row_cnt == LAST_ROW) state_next = DONE;
      DONE:    state_next = FILL;
      default: state_next = IDLE;
    endcase
  end

  // Raster advance of the block index with wrap back to (1,1).
  always_comb begin
    bx_next = bx;
    by_next = by;
    if (bx == BX_MAX) begin
      bx_next = 8'd1;
      by_next = (by == BY_MAX) ? 8'd1 : by + 8'd1;
    end else begin
      bx_next = bx + 8'd1;
    end
  end

  // Address generation: three consecutive words per row, then jump to the
  // next frame row. The address is not advanced on the final issue so it
  // holds the last window address until the next block starts.
  always_ff @(posedge clk) begin
    if (rst) begin
      addr      <= 32'd0;
      issue_cnt <= 7'd0;
      word_cnt  <= 2'd0;
      cap_cnt   <= 7'd0;
      cap_valid <= 1'b0;
      bx        <= 8'd1;
      by        <= 8'd1;
    end else begin
      cap_valid <= issue;
      if (state == IDLE && bus.en) begin
        addr      <= block_base(bx, by);
        issue_cnt <= 7'd0;
        word_cnt  <= 2'd0;
        cap_cnt   <= 7'd0;
      end else if (state == DONE) begin
        bx        <= bx_next;
        by        <= by_next;
        addr      <= block_base(bx_next, by_next);
        issue_cnt <= 7'd0;
        word_cnt  <= 2'd0;
        cap_cnt   <= 7'd0;
      end else if (state == FILL) begin
        if (issue) begin
          issue_cnt <= issue_cnt + 7'd1;
          word_cnt  <= (word_cnt == 2'd2) ? 2'd0 : word_cnt + 2'd1;
          if (issue_cnt != LAST_IDX)
            addr <= (word_cnt == 2'd2) ? addr + ROW_STEP : addr + 32'd1;
        end
        if (cap_valid) cap_cnt <= cap_cnt + 7'd1;
      end
    end
  end

  // Window storage; captures follow issues by one cycle via cap_valid.
  always_ff @(posedge clk) begin
    if (!rst && state == FILL && cap_valid && cap_cnt < NUM_WORDS)
      ram[cap_cnt] <= bus.ref_in;
  end

  // Row to present next cycle: row 0 when streaming starts, otherwise the
  // row after the current one.
  always_comb begin
    rd_row = 5'd0;
    if (state == STREAM && row_cnt != LAST_ROW) rd_row = row_cnt + 5'd1;
    rd_base  = 7'(rd_row) * 7'd3;
    row_data = {ram[rd_base], ram[rd_base + 7'd1], ram[rd_base + 7'd2][63:8]};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      bus.ref_out    <= '0;
      bus.sram_ready <= 1'b0;
      bus.next_block <= 1'b0;
      row_cnt        <= 5'd0;
    end else begin
      bus.sram_ready <= (state_next == STREAM);
      bus.next_block <= (state_next == DONE);
      bus.ref_out    <= (state_next == STREAM) ? row_data : '0;
      if (state == STREAM && state_next == STREAM) row_cnt <= row_cnt + 5'd1;
      else                                         row_cnt <= 5'd0;
    end
  end

  assign bus.ref_mem_addr = addr;

endmodule

// File: tb/tb_ref_sram.sv
// tb_ref_sram
// Directed bench for ref_sram: reset behaviour, first block, en gap, full
// 36-block raster wrap and reset during streaming. A registered reference
// memory model produces ref_in from ref_mem_addr one cycle later.
module tb_ref_sram;

  localparam int W = 8;
  localparam int H = 64;

  logic clk;
  logic rst;
  int   checks;
  int   failures;

  ref_sram_if bus_if ();

  ref_sram #(.FRAME_W_WORDS(W), .FRAME_H(H)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Pixel (x,y) = (x + 3y) & 0xFF, eight pixels per word, pixel 0 in MSB.
  function automatic logic [63:0] memWord(input logic [31:0] a);
    logic [63:0] v;
    int x0, y;
    x0 = 8 * (int'(a) % W);
    y  = int'(a) / W;
    for (int k = 0; k < 8; k++) v[63 - 8*k -: 8] = 8'((x0 + k + 3*y) & 255);
    return v;
  endfunction

  function automatic logic [183:0] expRow(input int bx, input int by, input int i);
    logic [183:0] v;
    int y;
    y = 8*by - 8 + i;
    for (int j = 0; j < 23; j++) v[183 - 8*j -: 8] = 8'((8*(bx-1) + j + 3*y) & 255);
    return v;
  endfunction

  // Integrator registers ref_data once.
  always @(posedge clk) bus_if.ref_in <= bus_if.en ? memWord(bus_if.ref_mem_addr) : 64'd0;

  task automatic checkOutput(input string tag, input logic [183:0] obs, input logic [183:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic applyStimulus(input logic r, input logic e);
    rst       = r;
    bus_if.en = e;
    @(posedge clk);
    #1;
  endtask

  // Entered at the first FILL cycle of block (bx,by); leaves at the first
  // FILL cycle of the following block.
  task automatic runBlock(input int bx, input int by, input int gap_at, input int gap_len);
    logic [31:0] exp_addr [0:68];
    int idx, cyc;
    logic e;
    for (int r = 0; r < 23; r++)
      for (int w = 0; w < 3; w++)
        exp_addr[3*r + w] = 32'((8*by - 8 + r) * W + (bx - 1) + w);
    idx = 0;
    cyc = 0;
    while (!bus_if.sram_ready && cyc < 300) begin
      e = !(cyc >= gap_at && cyc < gap_at + gap_len);
      if (idx < 69) checkOutput("fill_addr", 184'(bus_if.ref_mem_addr), 184'(exp_addr[idx]));
      checkOutput("fill_next_block", 184'(bus_if.next_block), 184'd0);
      if (e && idx < 69) idx++;
      applyStimulus(1'b0, e);
      cyc++;
    end
    checkOutput("ready_latency", 184'(cyc), 184'(70 + gap_len));
    checkOutput("addr_hold", 184'(bus_if.ref_mem_addr), 184'(exp_addr[68]));
    for (int i = 0; i < 23; i++) begin
      checkOutput("stream_ready", 184'(bus_if.sram_ready), 184'd1);
      checkOutput("stream_row", bus_if.ref_out, expRow(bx, by, i));
      checkOutput("stream_next_block", 184'(bus_if.next_block), 184'd0);
      applyStimulus(1'b0, 1'b1);
    end
    checkOutput("done_next_block", 184'(bus_if.next_block), 184'd1);
    checkOutput("done_ready", 184'(bus_if.sram_ready), 184'd0);
    checkOutput("done_ref_out", bus_if.ref_out, 184'd0);
    applyStimulus(1'b0, 1'b1);
    checkOutput("after_done_next_block", 184'(bus_if.next_block), 184'd0);
  endtask

  initial begin
    int cyc;
    checks    = 0;
    failures  = 0;
    rst       = 1'b1;
    bus_if.en = 1'b0;

    applyStimulus(1'b1, 1'b0);
    applyStimulus(1'b1, 1'b0);
    for (int i = 0; i < 10; i++) begin
      applyStimulus(1'b0, 1'b0);
      checkOutput("idle_addr", 184'(bus_if.ref_mem_addr), 184'd0);
      checkOutput("idle_ref_out", bus_if.ref_out, 184'd0);
      checkOutput("idle_ready", 184'(bus_if.sram_ready), 184'd0);
      checkOutput("idle_next_block", 184'(bus_if.next_block), 184'd0);
    end

    // First enabled cycle in IDLE moves to FILL.
    applyStimulus(1'b0, 1'b1);

    // Full raster of 36 blocks; block (2,1) carries a 5-cycle en gap.
    for (int by = 1; by <= 6; by++)
      for (int bx = 1; bx <= 6; bx++)
        if (bx == 2 && by == 1) runBlock(bx, by, 20, 5);
        else                    runBlock(bx, by, 1000, 0);

    // Wrap back to (1,1).
    runBlock(1, 1, 1000, 0);

    // Reset in the middle of streaming block (2,1).
    cyc = 0;
    while (!bus_if.sram_ready && cyc < 300) begin
      applyStimulus(1'b0, 1'b1);
      cyc++;
    end
    checkOutput("pre_reset_latency", 184'(cyc), 184'd70);
    for (int i = 0; i < 5; i++) applyStimulus(1'b0, 1'b1);
    applyStimulus(1'b1, 1'b1);
    checkOutput("reset_ready", 184'(bus_if.sram_ready), 184'd0);
    checkOutput("reset_ref_out", bus_if.ref_out, 184'd0);
    checkOutput("reset_addr", 184'(bus_if.ref_mem_addr), 184'd0);
    checkOutput("reset_next_block", 184'(bus_if.next_block), 184'd0);
    applyStimulus(1'b0, 1'b1);
    runBlock(1, 1, 1000, 0);
    runBlock(2, 1, 1000, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
